mem_region_decoder: RTL and testbench

Parametrised, handshaked memory-map decoder between the CPU address bus and its ROM/RAM/peripheral targets. It compares a sampled address against NREG base/mask regions and holds a registered one-hot select for the whole access. It inserts per-region wait states before signalling completion and reports unmapped accesses as decode errors, counting them in a saturating counter.

---
 rtl/mem_region_decoder.sv | 121 ++++++++++++
 tb/tb_mem_region_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_decoder.sv
// Handshaked memory-map decoder: matches a sampled address against NREG base/mask
// regions, holds a one-hot select for the access, inserts wait states, flags unmapped hits.
`timescale 1ns/1ps

module mem_region_decoder #(
  parameter int unsigned              ADDR_W = 13,
  parameter int unsigned              NREG   = 2,
  parameter logic [NREG*ADDR_W-1:0]   BASE   = {13'h1000, 13'h0000},
  parameter logic [NREG*ADDR_W-1:0]   MASK   = {13'h1000, 13'h1000},
  parameter logic [NREG*4-1:0]        WAIT   = {4'd0, 4'd1}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   sel,
  output logic              ready,
  output logic              err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic [7:0]      err_cnt_q;

  logic [NREG-1:0] hit_oh;
  logic [3:0]      hit_wait;
  logic            hit_any;

  // Priority match: the first (lowest-index) hitting region claims the access,
  // so hit_oh can never carry more than one set bit.
  always_comb begin
    hit_oh   = '0;
    hit_wait = '0;
    hit_any  = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (!hit_any &&
          ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
           (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]))) begin
        hit_oh[i] = 1'b1;
        hit_wait  = WAIT[i*4 +: 4];
        hit_any   = 1'b1;
      end
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ready   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (req) begin
          if (hit_any) begin
            sel_d   = hit_oh;
            cnt_d   = hit_wait;
            state_d = ACCESS;
          end else begin
            state_d = ERROR;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready   = 1'b1;
          sel_d   = '0;
          state_d = IDLE;
        end
      end
      ERROR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      // Counted on the edge leaving ERROR; sticks at 8'hFF.
      if (state_q == ERROR && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign sel     = sel_q;
  assign busy    = (state_q != IDLE);
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Scoreboard bench for mem_region_decoder: a default-map instance and a 3-region
// instance with overlap and unmapped space, driven with directed and random accesses.
`timescale 1ns/1ps

module tb_mem_region_decoder;

  typedef struct {
    logic [2:0] sel;
    bit         err;
    longint     due;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v     [2];
  logic [12:0] addr_v    [2];
  logic [1:0]  sel_a;
  logic [2:0]  sel_b;
  logic [2:0]  sel_v     [2];
  logic        ready_v   [2];
  logic        err_v     [2];
  logic        busy_v    [2];
  logic [7:0]  err_cnt_v [2];

  assign sel_v[0] = {1'b0, sel_a};
  assign sel_v[1] = sel_b;

  // Region tables of both instances: index [dut][region].
  int unsigned rg_n    [2]    = '{2, 3};
  int unsigned rg_base [2][3] = '{'{32'h0000, 32'h1000, 32'h0}, '{32'h0000, 32'h0800, 32'h0100}};
  int unsigned rg_mask [2][3] = '{'{32'h1000, 32'h1000, 32'h0}, '{32'h1800, 32'h1800, 32'h0100}};
  int unsigned rg_wait [2][3] = '{'{1, 0, 0}, '{1, 3, 5}};

  longint      cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned model_cnt [2] = '{0, 0};
  exp_t        sbq [2][$];
  exp_t        mon_e;

  mem_region_decoder dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .addr(addr_v[0]),
    .sel(sel_a), .ready(ready_v[0]), .err(err_v[0]), .busy(busy_v[0]), .err_cnt(err_cnt_v[0])
  );

  mem_region_decoder #(
    .ADDR_W(13),
    .NREG  (3),
    .BASE  ({13'h0100, 13'h0800, 13'h0000}),
    .MASK  ({13'h0100, 13'h1800, 13'h1800}),
    .WAIT  ({4'd5, 4'd3, 4'd1})
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .addr(addr_v[1]),
    .sel(sel_b), .ready(ready_v[1]), .err(err_v[1]), .busy(busy_v[1]), .err_cnt(err_cnt_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Reference: first region whose masked bits match wins; no match is a decode error.
  // Ready is due WAIT cycles after the cycle following the sampling edge.
  function automatic exp_t model(input int d, input logic [12:0] a, input int extra);
    exp_t e;
    e.sel = '0;
    e.err = 1'b1;
    e.due = cyc + 1 + extra;
    for (int i = 0; i < int'(rg_n[d]); i++) begin
      if (e.err && ((32'(a) & rg_mask[d][i]) == (rg_base[d][i] & rg_mask[d][i]))) begin
        e.sel = 3'(1 << i);
        e.err = 1'b0;
        e.due = e.due + longint'(rg_wait[d][i]);
      end
    end
    return e;
  endfunction

  // Monitor: compares every cycle, pops the scoreboard on each ready pulse.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!busy_v[d]) begin
        check("idle_sel", d, 32'(sel_v[d]), 32'h0);
        check("idle_ready", d, 32'(ready_v[d]), 32'h0);
        check("idle_err", d, 32'(err_v[d]), 32'h0);
      end else if (sbq[d].size() == 0) begin
        check("unexpected_busy", d, 32'h1, 32'h0);
      end else begin
        mon_e = sbq[d][0];
        check("sel", d, 32'(sel_v[d]), 32'(mon_e.sel));
        if (ready_v[d]) begin
          sbq[d].delete(0);
          check("err", d, 32'(err_v[d]), 32'(mon_e.err));
          check("latency", d, 32'(cyc), 32'(mon_e.due));
          check("err_cnt", d, 32'(err_cnt_v[d]), model_cnt[d]);
          if (mon_e.err && model_cnt[d] < 255) model_cnt[d]++;
        end else begin
          check("early_err", d, 32'(err_v[d]), 32'h0);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the ready cycle.
  task automatic access(input int d, input logic [12:0] a, input bit junk);
    bit done = 1'b0;
    sbq[d].push_back(model(d, a, 0));
    req_v[d]  = 1'b1;
    addr_v[d] = a;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready_v[d]) begin
        req_v[d] = 1'b0;
        done     = 1'b1;
      end else if (junk) begin
        req_v[d]  = 1'($urandom);
        addr_v[d] = 13'($urandom);
      end else begin
        req_v[d] = 1'b0;
      end
    end
    if (!done) begin
      check("timeout", d, 32'h0, 32'h1);
      req_v[d] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] a;
    req_v  = '{1'b1, 1'b1};
    addr_v = '{13'h1234, 13'h1234};
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_sel", d, 32'(sel_v[d]), 32'h0);
      check("rst_ready", d, 32'(ready_v[d]), 32'h0);
      check("rst_err", d, 32'(err_v[d]), 32'h0);
      check("rst_busy", d, 32'(busy_v[d]), 32'h0);
      check("rst_err_cnt", d, 32'(err_cnt_v[d]), 32'h0);
    end

    // Release between edges with req held: the first edge must start a transaction.
    sbq[0].push_back(model(0, 13'h1234, 0));
    sbq[1].push_back(model(1, 13'h1234, 0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("leave_idle", 0, 32'(busy_v[0]), 32'h1);
    check("leave_idle", 1, 32'(busy_v[1]), 32'h1);
    req_v = '{1'b0, 1'b0};
    @(negedge clk);

    // Legacy map: ROM with one wait state, RAM with none.
    access(0, 13'h0004, 1'b0);
    @(negedge clk);
    access(0, 13'h1004, 1'b0);
    @(negedge clk);

    // req held high on a zero-wait region: ready every other cycle.
    for (int k = 0; k < 4; k++) sbq[0].push_back(model(0, 13'h1004, 2 * k));
    req_v[0]  = 1'b1;
    addr_v[0] = 13'h1004;
    repeat (7) @(negedge clk);
    req_v[0] = 1'b0;
    @(negedge clk);

    // Overlap priority, mid-access bus noise, unmapped access.
    access(1, 13'h0100, 1'b0);
    @(negedge clk);
    access(1, 13'h0805, 1'b1);
    @(negedge clk);
    access(1, 13'h1EFF, 1'b0);
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      repeat (150) begin
        access(d, 13'($urandom), 1'($urandom));
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    // Unmapped on dut_b: addr[12]=1 misses regions 0/1, addr[8]=0 misses region 2.
    repeat (300) begin
      a    = 13'($urandom) | 13'h1000;
      a[8] = 1'b0;
      access(1, a, 1'b0);
      @(negedge clk);
    end
    check("err_cnt_sat", 1, 32'(err_cnt_v[1]), 32'hFF);

    // Abort mid-access with cnt=2 on the 3-wait region.
    sbq[1].push_back(model(1, 13'h0805, 0));
    req_v[1]  = 1'b1;
    addr_v[1] = 13'h0805;
    @(negedge clk);
    req_v[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    model_cnt = '{0, 0};
    #1;
    check("abort_sel", 1, 32'(sel_v[1]), 32'h0);
    check("abort_ready", 1, 32'(ready_v[1]), 32'h0);
    check("abort_busy", 1, 32'(busy_v[1]), 32'h0);
    check("abort_err_cnt", 1, 32'(err_cnt_v[1]), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    access(1, 13'h0805, 1'b0);
    @(negedge clk);
    access(0, 13'h0004, 1'b0);
    @(negedge clk);

    check("sb_empty", 0, 32'(sbq[0].size()), 32'h0);
    check("sb_empty", 1, 32'(sbq[1].size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
